// File: rtl/interweave_sequencer.sv
// interweave_sequencer: runs one activation vector through N_LAYERS passes of an
// external combinational interweave layer. Each layer fetches its ternary weight
// word from a synchronous memory, then latches the interweave output back into
// the activation register as the next layer's input.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   s_data_in/valid/ready   input activation (valid/ready)
//   m_data_out/valid/ready  result vector (valid/ready)
//   w_addr_out, w_ren_out   weight memory read request (one pulse per layer)
//   w_rdata_in              weight word, W_LATENCY cycles after w_ren_out
//   iw_x/w/trit_out         drive the interweave instance
//   iw_y_in                 interweave result
//   busy_out, layer_out     status / debug
module interweave_sequencer #(
  parameter int unsigned X_SIZE    = 729,
  parameter int unsigned W_SIZE    = 2187,
  parameter int unsigned TRIT_SIZE = 4,
  parameter int unsigned NUM_TRITS = 5,
  parameter int unsigned N_LAYERS  = 10,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned W_LATENCY = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [X_SIZE-1:0]    s_data_in,
  input  logic                 s_valid_in,
  output logic                 s_ready_out,
  output logic [X_SIZE-1:0]    m_data_out,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic [ADDR_W-1:0]    w_addr_out,
  output logic                 w_ren_out,
  input  logic [W_SIZE-1:0]    w_rdata_in,
  output logic [X_SIZE-1:0]    iw_x_out,
  output logic [W_SIZE-1:0]    iw_w_out,
  output logic [TRIT_SIZE-1:0] iw_trit_out,
  input  logic [X_SIZE-1:0]    iw_y_in,
  output logic                 busy_out,
  output logic [ADDR_W-1:0]    layer_out
);

  localparam int unsigned WaitW = (W_LATENCY < 1) ? 1 : $clog2(W_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StEval, StDone} state_e;

  state_e                 state_q, state_d;
  logic [X_SIZE-1:0]      x_q, x_d;
  logic [W_SIZE-1:0]      w_q, w_d;
  logic [ADDR_W-1:0]      layer_q, layer_d;
  logic [TRIT_SIZE-1:0]   trit_q, trit_d;
  logic [WaitW-1:0]       wait_q, wait_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      x_q     <= '0;
      w_q     <= '0;
      layer_q <= '0;
      trit_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      layer_q <= layer_d;
      trit_q  <= trit_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    w_d         = w_q;
    layer_d     = layer_q;
    trit_d      = trit_q;
    wait_d      = wait_q;
    s_ready_out = 1'b0;
    m_valid_out = 1'b0;
    w_ren_out   = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_ready_out = 1'b1;
        if (s_valid_in) begin
          x_d     = s_data_in;
          layer_d = '0;
          trit_d  = '0;
          wait_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // wait_q is zero only on the entry cycle, so the read strobe is a single pulse.
        w_ren_out = (wait_q == '0);
        wait_d    = wait_q + WaitW'(1);
        if (wait_q == WaitW'(W_LATENCY)) begin
          w_d     = w_rdata_in;
          wait_d  = '0;
          state_d = StEval;
        end
      end
      StEval: begin
        x_d = iw_y_in;
        if (layer_q == ADDR_W'(N_LAYERS - 1)) begin
          state_d = StDone;
        end else begin
          layer_d = layer_q + ADDR_W'(1);
          trit_d  = (trit_q == TRIT_SIZE'(NUM_TRITS - 1)) ? '0 : trit_q + TRIT_SIZE'(1);
          wait_d  = '0;
          state_d = StFetch;
        end
      end
      StDone: begin
        m_valid_out = 1'b1;
        if (m_ready_in) begin
          // Clear the layer index so the address reads 0 while idle.
          layer_d = '0;
          trit_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m_data_out  = x_q;
  assign iw_x_out    = x_q;
  assign iw_w_out    = w_q;
  assign iw_trit_out = trit_q;
  assign w_addr_out  = layer_q;
  assign layer_out   = layer_q;
  assign busy_out    = (state_q != StIdle);

  // Interweave outputs zero for strides >= 5; the select must never get there.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (trit_q < TRIT_SIZE'(5)) else $error("trit select out of range");
    end
  end

endmodule

// File: doc/interweave_sequencer.md
# interweave_sequencer

Multi-layer sequencer for the combinational `interweave` layer. It accepts one activation vector, fetches each layer's ternary weight word from a synchronous weight memory, and drives the interweave datapath once per layer. Trit (stride) selection follows the layer index modulo `NUM_TRITS`. Each layer's `y` is fed back as the next layer's `x`. The final vector is returned on a valid/ready output port. It sits between the input activation stream and the classifier head, and owns the interweave instance's `x`, `w` and `trit` inputs.

## Interface
- `X_SIZE`, 729, activation width in bits; matches the interweave instance.
- `W_SIZE`, 2187, weight word width; must equal 3*`X_SIZE`.
- `TRIT_SIZE`, 4, width of the `trit` select.
- `NUM_TRITS`, 5, number of stride values used; `trit` cycles 0..`NUM_TRITS`-1.
- `N_LAYERS`, 10, layers per inference; must be ≥1.
- `ADDR_W`, 8, weight memory address width; 2**`ADDR_W` ≥ `N_LAYERS`.
- `W_LATENCY`, 2, weight memory read latency in cycles; must be ≥1.
- `clk_in`  in  1  clock.
- `rst_in`  in  1  synchronous reset, active high.
- `s_data_in`  in  `X_SIZE`  input activation vector.
- `s_valid_in`  in  1  input valid.
- `s_ready_out`  out  1  input ready.
- `m_data_out`  out  `X_SIZE`  result vector.
- `m_valid_out`  out  1  result valid.
- `m_ready_in`  in  1  result ready.
- `w_addr_out`  out  `ADDR_W`  weight memory address; equals the layer index.
- `w_ren_out`  out  1  weight read strobe; one-cycle pulse.
- `w_rdata_in`  in  `W_SIZE`  weight data; valid exactly `W_LATENCY` cycles after `w_ren_out`.
- `iw_x_out`  out  `X_SIZE`  drives interweave `x`.
- `iw_w_out`  out  `W_SIZE`  drives interweave `w`.
- `iw_trit_out`  out  `TRIT_SIZE`  drives interweave `trit`.
- `iw_y_in`  in  `X_SIZE`  interweave `y`.
- `busy_out`  out  1  high in any state other than IDLE.
- `layer_out`  out  `ADDR_W`  current layer index, for debug.

## Operation
- State registers: `x_reg` (`X_SIZE` bits), `w_reg` (`W_SIZE` bits), `layer` counter, `trit` counter, `wait` counter.
- Continuous assignments: `iw_x_out`=`x_reg`, `iw_w_out`=`w_reg`, `iw_trit_out`=`trit`, `m_data_out`=`x_reg`.
- **IDLE**
  - `s_ready_out`=1.
  - On `s_valid_in && s_ready_out`: `x_reg`←`s_data_in`; `layer`←0; `trit`←0; go to FETCH.
- **FETCH**
  - Entry cycle: `w_ren_out`=1 and `w_addr_out`=`layer`; `wait`←0.
  - Each following cycle increments `wait`.
  - In the cycle where `wait`==`W_LATENCY`: `w_reg`←`w_rdata_in`; go to EVAL.
  - Total FETCH duration: `W_LATENCY`+1 cycles.
- **EVAL** (one cycle)
  - `x_reg`←`iw_y_in`.
  - If `layer`==`N_LAYERS`-1: go to DONE.
  - Otherwise: `layer`++; `trit`←(`trit`==`NUM_TRITS`-1) ? 0 : `trit`+1; go to FETCH.
- **DONE**
  - `m_valid_out`=1; `m_data_out` holds stable.
  - On `m_ready_in`: go to IDLE.
- `s_ready_out`=0 in every state except IDLE. Input is never accepted during an inference, and never in the same cycle as the DONE handshake.
- `trit` is an explicit wrapping counter; no modulo operator. It is zero-extended to `TRIT_SIZE`.
- `w_ren_out` pulses exactly once per layer. No other memory reads are issued.
- `w_addr_out` holds `layer` in all states. It is 0 in IDLE.
- Out-of-range `trit` values (≥5, zero output from interweave) cannot occur when `NUM_TRITS`≤5; this is enforced by assertion.

## Timing
- Reset values: state=IDLE; `x_reg`, `w_reg`, `layer`, `trit`, `wait` = 0.
- Output values during reset: `s_ready_out`=1 (IDLE); `m_valid_out`, `w_ren_out`, `busy_out` = 0; all data and address outputs 0.
- Reset mid-inference: returns to IDLE on the next edge. The in-flight inference is discarded. Late `w_rdata_in` arrivals are ignored.
- Per-layer cost: `W_LATENCY`+2 cycles.
- Accept at edge t0 → `m_valid_out` first high at cycle t0+`N_LAYERS`*(`W_LATENCY`+2)+1.
- Defaults give 40 cycles in FETCH/EVAL; `m_valid_out` high at cycle 41 after acceptance.
- DONE holds indefinitely under backpressure. After the handshake, the earliest next accept is one cycle later, in IDLE.
- `busy_out` is high from the cycle after acceptance through the DONE handshake cycle.

## Test plan
- **Single inference, defaults, `W_LATENCY`=2, ready tied high.** Inputs: x=one-hot bit 0; weight mem[l]=l-dependent pattern. Required: `w_ren_out` pulses at cycles 1,5,9,…,37; addresses 0..9; `iw_trit_out` sequence 0,1,2,3,4,0,1,2,3,4; `m_valid_out` at cycle 41; `m_data_out` matches the golden model.
- **`N_LAYERS`=7, `NUM_TRITS`=5.** Required: trit sequence 0,1,2,3,4,0,1; exactly 7 read pulses.
- **Backpressure.** Hold `m_ready_in`=0 for 20 cycles in DONE. Required: `m_valid_out` stays high; `m_data_out` stable; `s_ready_out`=0; no reads issued.
- **Input while busy.** Assert `s_valid_in` with new data during layer 3. Required: not accepted; result equals that of the first vector only; the second vector is accepted in IDLE after DONE.
- **Reset mid-FETCH.** Assert `rst_in` one cycle after a `w_ren_out` pulse in layer 4. Required: next cycle is IDLE with all outputs at reset values; delayed `w_rdata_in` has no effect; a fresh inference then matches the golden model.
- **`W_LATENCY`=1 and `W_LATENCY`=4.** Required: `m_valid_out` at cycles 31 and 61 after acceptance, respectively; results identical to the defaults run.
